// File: rtl/sum_decomp_pkg.sv
// Shared types and helpers for the triangular-sum decomposer.
package sum_decomp_pkg;

  localparam int W_DEF = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Triangular number n(n-1)/2, widened to 32 bits so n up to ~65k cannot wrap.
  function automatic logic [31:0] tri_num(input logic [31:0] n);
    return (n * (n - 32'd1)) >> 1;
  endfunction

endpackage

// File: rtl/sum_decomp_dp.sv
// Remainder/counter datapath: load captures S, each step subtracts i and bumps i.
module sum_decomp_dp
  import sum_decomp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_sum,
  output logic [W-1:0] o_r,
  output logic [W-1:0] o_i,
  output logic         o_stop
);

  logic [W-1:0] r_r;
  logic [W-1:0] r_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_r <= '0;
      r_i <= '0;
    end else if (i_load) begin
      r_r <= i_sum;
      r_i <= '0;
    end else if (i_step) begin
      // Step is only issued while i <= r, so r cannot underflow.
      r_r <= r_r - r_i;
      r_i <= r_i + 1'b1;
    end
  end

  assign o_r    = r_r;
  assign o_i    = r_i;
  assign o_stop = (r_i > r_r);

endmodule

// File: rtl/sum_decomp.sv
// Recovers the largest n with n(n-1)/2 <= S plus the remainder, one subtraction per cycle.
module sum_decomp
  import sum_decomp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] sum_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] n_out,
  output logic [W-1:0] rem_out,
  output logic         exact
);

  state_t       r_state;
  logic [W-1:0] r_cap;
  logic [W-1:0] w_r;
  logic [W-1:0] w_i;
  logic         w_stop;
  logic         w_load;
  logic         w_step;

  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == RUN) && !w_stop;

  sum_decomp_dp #(.W(W)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_sum  (sum_in),
    .o_r    (w_r),
    .o_i    (w_i),
    .o_stop (w_stop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cap   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      n_out   <= '0;
      rem_out <= '0;
      exact   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_cap   <= sum_in;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (w_stop) begin
            r_state <= DONE;
            n_out   <= w_i;
            rem_out <= w_r;
            exact   <= (w_r == '0);
            done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_rem_lt_n: assert property (@(posedge clk) disable iff (!rst)
    done |-> (rem_out < n_out));
  a_exact: assert property (@(posedge clk) disable iff (!rst)
    done |-> (exact == (rem_out == '0)));
  a_r_bound: assert property (@(posedge clk) disable iff (!rst)
    (r_state == RUN) |-> (w_r <= r_cap));
  a_invariant: assert property (@(posedge clk) disable iff (!rst)
    (r_state == RUN) |-> ((32'(w_r) + tri_num(32'(w_i))) == 32'(r_cap)));

endmodule

// File: tb/tb_sum_decomp.sv
module tb_sum_decomp;
  import sum_decomp_pkg::*;

  localparam int W = 19;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] rem;
    logic         ex;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] sum_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] n_out;
  logic [W-1:0] rem_out;
  logic         exact;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  sum_decomp #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sum_in  (sum_in),
    .busy    (busy),
    .done    (done),
    .n_out   (n_out),
    .rem_out (rem_out),
    .exact   (exact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Waits for IDLE, presents start for one edge, optionally queues the expected result.
  task automatic issue(input logic [W-1:0] s, input logic [W-1:0] n, input logic [W-1:0] rem,
                       input logic ex, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk("idle_timeout", 32'(busy), 32'd0);
    start  = 1'b1;
    sum_in = s;
    if (push) begin
      e.n = n; e.rem = rem; e.ex = ex; e.cyc = cyc + 1 + int'(n) + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    sum_in = 19'h2AAAA;
  endtask

  // Monitor: pops an expectation on every done pulse and checks the pulse drops next cycle.
  initial begin
    bit   drop_pending;
    exp_t e;
    drop_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (drop_pending && rst) begin
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
      end
      drop_pending = 1'b0;
      if (rst && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("n_out", 32'(n_out), 32'(e.n));
          chk("rem_out", 32'(rem_out), 32'(e.rem));
          chk("exact", 32'(exact), 32'(e.ex));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          drop_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    int guard;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_n_out", 32'(n_out), 32'd0);
    chk("rst_rem_out", 32'(rem_out), 32'd0);
    chk("rst_exact", 32'(exact), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(19'd11175, 19'd150, 19'd0, 1'b1, 1'b1);
    issue(19'd0, 19'd1, 19'd0, 1'b1, 1'b1);
    issue(19'd11176, 19'd150, 19'd1, 1'b0, 1'b1);
    issue(19'd1, 19'd2, 19'd0, 1'b1, 1'b1);
    issue(19'd2, 19'd2, 19'd1, 1'b0, 1'b1);
    issue(19'd524287, 19'd1024, 19'd511, 1'b0, 1'b1);

    // A start pulse mid-run must be dropped, not queued.
    issue(19'd11175, 19'd150, 19'd0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    start  = 1'b1;
    sum_in = 19'd5;
    @(negedge clk);
    start  = 1'b0;

    // Asynchronous reset 50 cycles into a run clears everything at once.
    issue(19'd11175, 19'd0, 19'd0, 1'b0, 1'b0);
    repeat (49) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_n_out", 32'(n_out), 32'd0);
    chk("arst_rem_out", 32'(rem_out), 32'd0);
    chk("arst_exact", 32'(exact), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(19'd10, 19'd5, 19'd0, 1'b1, 1'b1);

    guard = 0;
    while (q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
